// File: rtl/uart_ip_pkg.sv
// Shared types and helpers for the UART core.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package uart_ip_pkg;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Parity bit for a word; zero-extension does not change the XOR, so any
  // word up to 32 bits can be passed in.
  function automatic logic calc_parity(input logic [31:0] data, input logic even);
    return even ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_ip_tx.sv
// UART transmitter: serialises a latched word (start, data LSB first, optional parity, stop).
// Latency: first TX bit one cycle after the first CTS=1 cycle following the latch; each bit lasts BAUD_TICKS.
// Backpressure: a request is held while CTS=0; tx_start is ignored while tx_busy=1; CTS never cuts a frame.
module uart_ip_tx
  import uart_ip_pkg::*;
#(
  parameter int UART_SIZE     = 8,
  parameter int BAUD_TICKS    = 1085,
  parameter int PARITY_ENABLE = 0,
  parameter int PARITY_TYPE   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [UART_SIZE-1:0] tx_data,
  input  logic                 tx_start,
  input  logic                 cts,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int CW = $clog2(BAUD_TICKS + 1);
  localparam int BW = $clog2(UART_SIZE + 1);

  tx_state_t            state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [BW-1:0]        bit_idx, bit_d;
  logic [UART_SIZE-1:0] sh, sh_d;
  logic                 par, par_d;
  logic                 busy_d, tx_d;
  logic                 last;

  assign last = (cnt == CW'(BAUD_TICKS - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= TX_IDLE;
    else        state <= state_d;
  end

  // Next state, bit timer and shift register; TX is derived from the next state so the pin is a flop
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    bit_d   = bit_idx;
    sh_d    = sh;
    par_d   = par;
    busy_d  = tx_busy;
    case (state)
      TX_IDLE: begin
        cnt_d = '0;
        if (!tx_busy && tx_start) begin
          sh_d   = tx_data;
          par_d  = calc_parity(32'(tx_data), PARITY_TYPE != 0);
          busy_d = 1'b1;
        end else if (tx_busy && cts) begin
          state_d = TX_START;
        end
      end
      TX_START: if (last) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = TX_DATA;
      end
      TX_DATA: if (last) begin
        cnt_d = '0;
        sh_d  = sh >> 1;
        if (bit_idx == BW'(UART_SIZE - 1)) state_d = (PARITY_ENABLE != 0) ? TX_PARITY : TX_STOP;
        else                               bit_d   = bit_idx + 1'b1;
      end
      TX_PARITY: if (last) begin
        cnt_d   = '0;
        state_d = TX_STOP;
      end
      TX_STOP: if (last) begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = sh_d[0];
      TX_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // Datapath and registered line output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      par     <= 1'b0;
      tx_busy <= 1'b0;
      tx      <= 1'b1;
    end else begin
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      sh      <= sh_d;
      par     <= par_d;
      tx_busy <= busy_d;
      tx      <= tx_d;
    end
  end

endmodule

// File: rtl/uart_ip.sv
// Full-duplex UART with RTS/CTS, optional parity and CRC-8 over received words. Macro UART_IP_RX_SYNC_EN adds a 2-flop RX synchronizer.
// Latency: done 9*BAUD_TICKS+SAMPLE_OFFSET+1 cycles after the start edge (+2 with UART_IP_RX_SYNC_EN), plus BAUD_TICKS with parity.
// Backpressure: RTS high only while the receiver is idle; transmit waits on CTS (see uart_ip_tx).
module uart_ip
  import uart_ip_pkg::*;
#(
  parameter int UART_SIZE     = 8,
  parameter int BAUD_RATE     = 115200,
  parameter int SYS_CLK_FREQ  = 125000000,
  parameter int SAMPLE_OFFSET = 180,
  parameter int PARITY_ENABLE = 0,
  parameter int PARITY_TYPE   = 0,
  parameter int CRC_ENABLE    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RX,
  output logic                 TX,
  output logic                 RTS,
  input  logic                 CTS,
  output logic [UART_SIZE-1:0] rx_data,
  output logic                 done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic [7:0]           rx_crc,
  input  logic [UART_SIZE-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy
);

  localparam int BAUD_TICKS = SYS_CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BAUD_TICKS + 1);
  localparam int BW = $clog2(UART_SIZE + 1);

  logic rx_in, rx_prev;

`ifdef UART_IP_RX_SYNC_EN
  logic [1:0] rx_sync;
  // Two-flop synchronizer for the asynchronous RX pin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], RX};
  end
  assign rx_in = rx_sync[1];
`else
  assign rx_in = RX;
`endif

  // CRC-8 of one word, fed MSB first
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [UART_SIZE-1:0] d);
    logic [7:0] c;
    c = crc;
    for (int i = UART_SIZE - 1; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  rx_state_t            rx_state, rx_state_d;
  logic [CW-1:0]        rx_cnt, rx_cnt_d;
  logic [BW-1:0]        rx_bit, rx_bit_d;
  logic [UART_SIZE-1:0] rx_sh, rx_sh_d;
  logic                 rx_par, rx_par_d;
  logic                 sample_now, load_d, perr_d, ferr_d;

  assign RTS = (rx_state == RX_IDLE);

  // RX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_d;
  end

  // RX next state: the timer counts from the start edge to the first sample, then sample to sample
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 1'b1;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_par_d   = rx_par;
    load_d     = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    sample_now = (rx_state == RX_START) ? (rx_cnt == CW'(SAMPLE_OFFSET))
                                        : (rx_cnt == CW'(BAUD_TICKS));
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = CW'(1);
        if (rx_prev && !rx_in) rx_state_d = RX_START;
      end
      RX_START: if (sample_now) begin
        rx_cnt_d   = CW'(1);
        rx_bit_d   = '0;
        rx_state_d = rx_in ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (sample_now) begin
        rx_cnt_d = CW'(1);
        rx_sh_d  = {rx_in, rx_sh[UART_SIZE-1:1]};
        if (rx_bit == BW'(UART_SIZE - 1)) rx_state_d = (PARITY_ENABLE != 0) ? RX_PARITY : RX_STOP;
        else                              rx_bit_d   = rx_bit + 1'b1;
      end
      RX_PARITY: if (sample_now) begin
        rx_cnt_d   = CW'(1);
        rx_par_d   = rx_in;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (sample_now) begin
        rx_state_d = RX_IDLE;
        ferr_d     = !rx_in;
        perr_d     = (PARITY_ENABLE != 0) &&
                     (rx_par != calc_parity(32'(rx_sh), PARITY_TYPE != 0));
        load_d     = rx_in && !perr_d;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX datapath, result pulses and running CRC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev       <= 1'b1;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      rx_par        <= 1'b0;
      rx_data       <= '0;
      done          <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_crc        <= 8'h00;
    end else begin
      rx_prev       <= rx_in;
      rx_cnt        <= rx_cnt_d;
      rx_bit        <= rx_bit_d;
      rx_sh         <= rx_sh_d;
      rx_par        <= rx_par_d;
      done          <= load_d;
      rx_parity_err <= perr_d;
      rx_frame_err  <= ferr_d;
      if (load_d) rx_data <= rx_sh;
      if (load_d && (CRC_ENABLE != 0)) rx_crc <= crc8_next(rx_crc, rx_sh);
    end
  end

  uart_ip_tx #(
    .UART_SIZE    (UART_SIZE),
    .BAUD_TICKS   (BAUD_TICKS),
    .PARITY_ENABLE(PARITY_ENABLE),
    .PARITY_TYPE  (PARITY_TYPE)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .cts     (CTS),
    .tx      (TX),
    .tx_busy (tx_busy)
  );

endmodule

// File: tb/tb_uart_ip.sv
// Directed bench for uart_ip: default build plus a parity/CRC instance.
// Latency: checks done at the exact cycle after the start edge and TX bit timing.
// Backpressure: exercises CTS hold-off, CTS drop mid-frame and ignored tx_start.
module tb_uart_ip;

`ifdef UART_IP_RX_SYNC_EN
  localparam int DONE_LAT = 9948;
`else
  localparam int DONE_LAT = 9946;
`endif
  localparam int BT = 1085;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1, rx_p = 1'b1, cts = 1'b1, tx_start = 1'b0, tx_start_p = 1'b0;
  logic [7:0] tx_data = 8'h00, tx_data_p = 8'h00;
  logic       tx, rts, done, perr, ferr, tx_busy;
  logic       tx_p, rts_p, done_p, perr_p, ferr_p, tx_busy_p;
  logic [7:0] rx_data, rx_crc, rx_data_p, rx_crc_p;

  int cyc = 0, frame_cyc = 0, done_at = 0;
  int done_n = 0, ferr_n = 0, perr_n = 0, done_p_n = 0, ferr_p_n = 0, perr_p_n = 0;
  int n_cmp = 0, n_bad = 0;

  always #4 clk = ~clk;

  uart_ip dut (
    .clk(clk), .reset(reset), .RX(rx), .TX(tx), .RTS(rts), .CTS(cts),
    .rx_data(rx_data), .done(done), .rx_parity_err(perr), .rx_frame_err(ferr),
    .rx_crc(rx_crc), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  uart_ip #(.PARITY_ENABLE(1), .PARITY_TYPE(0), .CRC_ENABLE(1)) dut_p (
    .clk(clk), .reset(reset), .RX(rx_p), .TX(tx_p), .RTS(rts_p), .CTS(cts),
    .rx_data(rx_data_p), .done(done_p), .rx_parity_err(perr_p), .rx_frame_err(ferr_p),
    .rx_crc(rx_crc_p), .tx_data(tx_data_p), .tx_start(tx_start_p), .tx_busy(tx_busy_p)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin done_n++; done_at = cyc; end
    if (ferr) ferr_n++;
    if (perr) perr_n++;
    if (done_p) done_p_n++;
    if (ferr_p) ferr_p_n++;
    if (perr_p) perr_p_n++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit to_p, input logic v);
    if (to_p) rx_p = v;
    else      rx   = v;
  endtask

  task automatic send_frame(input bit to_p, input logic [7:0] d, input bit with_par,
                            input logic par, input logic stop);
    frame_cyc = cyc;
    drive(to_p, 1'b0);
    tick(BT);
    for (int i = 0; i < 8; i++) begin
      drive(to_p, d[i]);
      tick(BT);
    end
    if (with_par) begin
      drive(to_p, par);
      tick(BT);
    end
    drive(to_p, stop);
    tick(BT);
    drive(to_p, 1'b1);
  endtask

  initial begin : stim
    logic exp_bits [8];
    int w, fall_cyc;
    exp_bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset
    tick(100);
    reset = 1'b1;
    tick(2);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rts", 32'(rts), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_crc", 32'(rx_crc), 32'h00);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_errs", 32'({perr, ferr}), 32'd0);

    // Good 8N1 frame 0x53
    send_frame(1'b0, 8'h53, 1'b0, 1'b0, 1'b1);
    tick(200);
    check("f53_done_cnt", 32'(done_n), 32'd1);
    check("f53_latency", 32'(done_at - frame_cyc), 32'(DONE_LAT));
    check("f53_rx_data", 32'(rx_data), 32'h53);
    check("f53_no_ferr", 32'(ferr_n), 32'd0);
    check("f53_crc_off", 32'(rx_crc), 32'h00);

    // Glitch shorter than the start sample point
    rx = 1'b0;
    tick(50);
    check("glitch_rts_low", 32'(rts), 32'd0);
    tick(50);
    rx = 1'b1;
    tick(400);
    check("glitch_rts_high", 32'(rts), 32'd1);
    tick(2000);
    check("glitch_no_done", 32'(done_n), 32'd1);
    check("glitch_rx_data", 32'(rx_data), 32'h53);

    // Frame 0xA5 with a bad stop bit
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    tick(200);
    check("ferr_cnt", 32'(ferr_n), 32'd1);
    check("ferr_no_done", 32'(done_n), 32'd1);
    check("ferr_rx_data", 32'(rx_data), 32'h53);

    // Odd parity instance: 0x53 has four ones, so the correct parity bit is 1
    send_frame(1'b1, 8'h53, 1'b1, 1'b1, 1'b1);
    tick(200);
    check("par_ok_done", 32'(done_p_n), 32'd1);
    check("par_ok_data", 32'(rx_data_p), 32'h53);
    check("par_ok_no_perr", 32'(perr_p_n), 32'd0);
    check("par_ok_crc", 32'(rx_crc_p), 32'hBE);
    send_frame(1'b1, 8'h53, 1'b1, 1'b0, 1'b1);
    tick(200);
    check("par_bad_perr", 32'(perr_p_n), 32'd1);
    check("par_bad_no_done", 32'(done_p_n), 32'd1);
    check("par_bad_crc_held", 32'(rx_crc_p), 32'hBE);
    check("par_bad_no_ferr", 32'(ferr_p_n), 32'd0);

    // Transmit 0x3C held off by CTS
    cts = 1'b0;
    tx_data = 8'h3C;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    tick(50);
    check("tx_held_line", 32'(tx), 32'd1);
    check("tx_held_busy", 32'(tx_busy), 32'd1);
    cts = 1'b1;
    w = 0;
    while (tx === 1'b1 && w < 20) begin
      tick(1);
      w++;
    end
    check("tx_start_seen", 32'(w < 20), 32'd1);
    fall_cyc = cyc;
    tick(BT / 2);
    check("tx_start_bit", 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(BT);
      check($sformatf("tx_bit%0d", i), 32'(tx), 32'(exp_bits[i]));
      if (i == 2) begin
        // CTS drop and a second request while busy must not disturb the frame
        cts = 1'b0;
        tx_data = 8'hFF;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        tick(-1 + 1);
      end
    end
    tick(BT - 1);
    check("tx_stop_bit", 32'(tx), 32'd1);
    check("tx_stop_busy", 32'(tx_busy), 32'd1);
    w = 0;
    while (tx_busy === 1'b1 && w < 2000) begin
      tick(1);
      w++;
    end
    check("tx_busy_clear_seen", 32'(w < 2000), 32'd1);
    check("tx_frame_len", 32'(cyc - fall_cyc), 32'(10 * BT));
    check("tx_ignored_req", 32'(tx_busy), 32'd0);
    cts = 1'b1;
    tick(20);
    check("tx_idle_after", 32'(tx), 32'd1);
    check("tx_idle_busy", 32'(tx_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_ip.md
Name: uart_ip

Overview:
- Full-duplex UART core with RTS/CTS hardware flow control, optional parity, and optional CRC-8 over received words.
- Receiver deserialises RX into UART_SIZE-bit words and pulses done for each valid frame.
- Transmitter serialises a parallel word onto TX, gated by CTS.
- Sits between a board-level serial pin pair and a simple valid/start parallel interface in the system clock domain.

Parameters:
- UART_SIZE, 8, data bits per frame, sent LSB first.
- BAUD_RATE, 115200, line rate in bps.
- SYS_CLK_FREQ, 125000000, clk frequency in Hz.
- BAUD_TICKS (localparam) = SYS_CLK_FREQ/BAUD_RATE, integer division; 1085 at defaults.
- SAMPLE_OFFSET, 180, clk cycles after each nominal RX bit start at which RX is sampled. Legal range is 0 < SAMPLE_OFFSET < BAUD_TICKS.
- PARITY_ENABLE, 0, 1 inserts and checks one parity bit after the data bits.
- PARITY_TYPE, 0, 0 = odd parity, 1 = even parity.
- CRC_ENABLE, 0, 1 enables the running CRC-8 over received words.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- RX  in  1  serial receive line; idles high.
- TX  out  1  serial transmit line; idles high.
- RTS  out  1  high = receiver ready to accept a frame.
- CTS  in  1  high = remote end permits transmission.
- rx_data  out  UART_SIZE  last correctly received word.
- done  out  1  one-cycle pulse when rx_data updates.
- rx_parity_err  out  1  one-cycle pulse on a parity mismatch.
- rx_frame_err  out  1  one-cycle pulse when the stop bit samples 0.
- rx_crc  out  8  running CRC-8 of received words.
- tx_data  in  UART_SIZE  word to transmit.
- tx_start  in  1  request to transmit tx_data.
- tx_busy  out  1  high while a transmit request is pending or a frame is in flight.

Behaviour:
- Reset values: TX=1, RTS=1, rx_data=0, done=0, both error pulses 0, rx_crc=0x00, tx_busy=0; both FSMs in IDLE.
- Reset assertion mid-frame aborts the frame immediately. No done or error pulse is produced for an aborted frame.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a 1-to-0 transition on RX starts a frame; the falling-edge cycle is cycle 0 and the bit timer starts there.
  - START: RX sampled at cycle SAMPLE_OFFSET. A 1 is a false start and the FSM returns to IDLE with no pulse.
  - DATA: bit i (0..UART_SIZE-1) sampled at cycle (i+1)*BAUD_TICKS+SAMPLE_OFFSET, shifted in LSB first.
  - PARITY (only when PARITY_ENABLE=1): sampled one BAUD_TICKS after the last data bit.
  - STOP: sampled one BAUD_TICKS after the previous sample.
    - Stop=1 and parity OK: rx_data loads the word and done pulses on the next cycle.
    - Stop=0: rx_frame_err pulses and rx_data is unchanged.
    - Parity mismatch: rx_parity_err pulses and rx_data is unchanged.
  - The FSM returns to IDLE on the cycle of the stop sample, so back-to-back frames are accepted.
- RTS is high only while the RX FSM is in IDLE.
- done latency at defaults with no parity: 8*1085+1085+180+1 = 9946 cycles after the start edge.
- CRC (CRC_ENABLE=1): polynomial 0x07, init 0x00, MSB-first over each word that produces done. rx_crc updates in the same cycle as done. With CRC_ENABLE=0, rx_crc is held at 0.
- TX FSM states: IDLE, START, DATA, PARITY, STOP; each bit lasts exactly BAUD_TICKS cycles.
  - tx_start while tx_busy=0 latches tx_data and sets tx_busy.
  - The frame begins on the first cycle with CTS=1 after the latch; it waits indefinitely while CTS=0.
  - tx_start while tx_busy=1 is ignored.
  - CTS falling mid-frame does not interrupt the frame in flight.
  - tx_busy clears at the end of the stop bit.

Optional Feature:
- Macro UART_IP_RX_SYNC_EN.
- Defined: RX passes through a 2-flop synchronizer before edge detection. All RX sample points and done shift 2 cycles later (done at 9948).
- Undefined: RX is used directly, with the latencies stated above.

Decomposition:
- Package uart_ip_pkg holds:
  - the rx_state_t and tx_state_t enums;
  - the CRC8_POLY constant (0x07);
  - a parity helper function.
- A single sub-module uart_ip_tx is natural. The receiver, CRC and flow control live in the top module.

Test Plan:
- Reset held low 100 cycles, then released with RX=1 and CTS=1 -> TX=1, RTS=1, done=0, rx_crc=0.
- Send 0x53 (8N1, 1085-cycle bits) -> exactly one done pulse ~9946 cycles after the start edge, with rx_data=0x53.
- RX low for 100 cycles then high (glitch) -> no done pulse, RTS returns high, rx_data unchanged.
- Frame 0xA5 with stop bit driven 0 -> rx_frame_err pulses once, no done, rx_data keeps its prior value.
- PARITY_ENABLE=1, PARITY_TYPE=0: 0x53 sent with a correct parity bit of 1 -> done with rx_data=0x53. Same frame with parity bit 0 -> rx_parity_err pulses.
- tx_start with tx_data=0x3C while CTS=0 -> TX stays high and tx_busy=1. Raise CTS -> TX emits start, 0,0,1,1,1,1,0,0, stop (each 1085 cycles) and tx_busy clears at the end of the stop bit.
